// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD/FCS, checks CRC-32, length
// and rx_er, and streams frame bytes out as 8-bit AXI-Stream with
// one-clock per-frame status pulses.
module gmii_rx_deframer #(
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int MAX_FRAME_LENGTH = 1522
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clk_enable,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       frame_good,
    output logic       frame_bad_fcs,
    output logic       frame_error
);

    localparam int          CW      = $clog2(MAX_FRAME_LENGTH + 1) + 1;
    localparam logic [31:0] POLY    = 32'hEDB8_8320;
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;
    localparam logic [7:0]  PRE     = 8'h55;
    localparam logic [7:0]  SFD     = 8'hD5;

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     crc_q, crc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    // Delay line: newest byte at [0], oldest at [4] once five are held;
    // the last four bytes of a frame are the FCS and never leave it.
    logic [4:0][7:0] dl_q, dl_d;
    logic [2:0]      fill_q, fill_d;

    logic [7:0] tdata_q, tdata_d;
    logic       tvalid_q, tvalid_d;
    logic       tlast_q, tlast_d;
    logic       tuser_q, tuser_d;
    logic       good_q, good_d;
    logic       bad_fcs_q, bad_fcs_d;
    logic       error_q, error_d;

    logic       full;
    logic       runt;
    logic       fcs_bad;

    // Reflected CRC-32, one byte LSB first, no final inversion.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    assign full    = (fill_q == 3'd5);
    assign runt    = (cnt_q < CW'(MIN_FRAME_LENGTH));
    assign fcs_bad = (crc_q != RESIDUE);

    // State and datapath register; outputs are rewritten every clock so
    // pulses never outlast one cycle even when clk_enable is sparse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            crc_q     <= 32'hFFFF_FFFF;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            dl_q      <= '0;
            fill_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            good_q    <= 1'b0;
            bad_fcs_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            dl_q      <= dl_d;
            fill_q    <= fill_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            good_q    <= good_d;
            bad_fcs_q <= bad_fcs_d;
            error_q   <= error_d;
        end
    end

    // Next-state, frame accounting and output generation on enabled edges.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        dl_d      = dl_q;
        fill_d    = fill_q;
        tdata_d   = '0;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        tuser_d   = 1'b0;
        good_d    = 1'b0;
        bad_fcs_d = 1'b0;
        error_d   = 1'b0;

        if (clk_enable) begin
            unique case (state_q)
                IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == PRE) begin
                            state_d = PREAMBLE;
                        end else if (gmii_rxd == SFD) begin
                            state_d = PAYLOAD;
                            crc_d   = 32'hFFFF_FFFF;
                            cnt_d   = '0;
                            err_d   = 1'b0;
                            fill_d  = '0;
                        end else begin
                            state_d = DROP;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_d = IDLE;
                    end else if (gmii_rxd == SFD) begin
                        state_d = PAYLOAD;
                        crc_d   = 32'hFFFF_FFFF;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        fill_d  = '0;
                    end else if (gmii_rxd != PRE) begin
                        state_d = DROP;
                        error_d = 1'b1;
                    end
                end

                PAYLOAD: begin
                    if (gmii_rx_dv && cnt_q >= CW'(MAX_FRAME_LENGTH)) begin
                        // Oversize: close the stream with what is held, drop the rest.
                        state_d  = DROP;
                        error_d  = 1'b1;
                        tvalid_d = full;
                        tlast_d  = full;
                        tuser_d  = full;
                        tdata_d  = full ? dl_q[4] : 8'h00;
                    end else if (gmii_rx_dv) begin
                        cnt_d  = cnt_q + 1'b1;
                        crc_d  = crc_byte(crc_q, gmii_rxd);
                        err_d  = err_q | gmii_rx_er;
                        dl_d   = {dl_q[3:0], gmii_rxd};
                        if (full) begin
                            tvalid_d = 1'b1;
                            tdata_d  = dl_q[4];
                        end else begin
                            fill_d = fill_q + 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        if (full) begin
                            tvalid_d  = 1'b1;
                            tlast_d   = 1'b1;
                            tdata_d   = dl_q[4];
                            tuser_d   = err_q | runt | fcs_bad;
                            error_d   = err_q | runt;
                            bad_fcs_d = !(err_q | runt) && fcs_bad;
                            good_d    = !(err_q | runt | fcs_bad);
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end

                DROP: begin
                    if (!gmii_rx_dv) state_d = IDLE;
                end

                default: state_d = IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign frame_good    = good_q;
    assign frame_bad_fcs = bad_fcs_q;
    assign frame_error   = error_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Randomized bench for gmii_rx_deframer: frames are built from byte
// queues and the expected stream/status is derived from frame-level rules.
module tb_gmii_rx_deframer;

    localparam int MINL = 64;
    localparam int MAXL = 1522;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_enable = 1'b1;
    logic [7:0] gmii_rxd = 8'h00;
    logic       gmii_rx_dv = 1'b0;
    logic       gmii_rx_er = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic       frame_good, frame_bad_fcs, frame_error;

    gmii_rx_deframer #(.MIN_FRAME_LENGTH(MINL), .MAX_FRAME_LENGTH(MAXL)) dut (
        .clock(clock), .reset_n(reset_n), .clk_enable(clk_enable),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .frame_good(frame_good), .frame_bad_fcs(frame_bad_fcs),
        .frame_error(frame_error)
    );

    always #4 clock = ~clock;

    // clk_enable pattern: high one cycle in en_div, changed on falling edges.
    int en_div = 1;
    int en_cnt = 0;
    always @(negedge clock) begin
        en_cnt     <= (en_cnt >= en_div - 1) ? 0 : en_cnt + 1;
        clk_enable <= (en_cnt == 0);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: collects beats and status pulses seen on falling edges.
    logic [7:0] q_data[$];
    bit         q_last[$];
    bit         q_user[$];
    int n_good, n_fcs, n_err, n_lone, n_consec;
    bit prev_v = 1'b0;

    always @(negedge clock) begin
        if (m_axis_tvalid) begin
            q_data.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
            q_user.push_back(m_axis_tuser);
        end
        if (frame_good) n_good++;
        if (frame_bad_fcs) n_fcs++;
        if (frame_error) n_err++;
        if ((frame_good || frame_bad_fcs || frame_error) && !(m_axis_tvalid && m_axis_tlast))
            n_lone++;
        if (m_axis_tvalid && prev_v) n_consec++;
        prev_v = m_axis_tvalid;
    end

    task automatic mon_clear();
        q_data.delete(); q_last.delete(); q_user.delete();
        n_good = 0; n_fcs = 0; n_err = 0; n_lone = 0; n_consec = 0;
    endtask

    // Reference CRC-32 (IEEE 802.3), table driven, with final inversion.
    bit [31:0] crc_tab[256];
    task automatic build_tab();
        for (int n = 0; n < 256; n++) begin
            bit [31:0] c;
            c = n;
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
    endtask

    logic [7:0] pay[$];
    bit         er[$];

    function automatic bit [31:0] crc32_of(input int len);
        bit [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) c = crc_tab[(c ^ pay[i]) & 8'hFF] ^ (c >> 8);
        return ~c;
    endfunction

    task automatic build(input int nd);
        bit [31:0] c;
        pay.delete(); er.delete();
        for (int i = 0; i < nd; i++) pay.push_back(8'($urandom));
        c = crc32_of(nd);
        for (int b = 0; b < 4; b++) pay.push_back(c[8*b +: 8]);
        for (int i = 0; i < nd + 4; i++) er.push_back(1'b0);
    endtask

    // One byte presented until an enabled edge has sampled it.
    task automatic drive(input bit dv, input logic [7:0] d, input bit e);
        gmii_rx_dv = dv; gmii_rxd = d; gmii_rx_er = e;
        do @(posedge clock); while (clk_enable !== 1'b1);
        #1;
    endtask

    task automatic send(input int npre, input logic [7:0] sfd, input int gap);
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, sfd, 1'b0);
        for (int i = 0; i < pay.size(); i++) drive(1'b1, pay[i], er[i]);
        for (int i = 0; i < gap; i++) drive(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    // mode 0: derive from frame rules; 1: preamble error; 2: no output at all.
    task automatic compare(input int mode, input string tag);
        int nb, stat, mism, nl, n;
        bit user, anyer, bad;
        bit [31:0] fcs;
        nb = 0; stat = 3; user = 0;
        n = pay.size();
        if (mode == 1) begin
            stat = 2;
        end else if (mode == 0) begin
            anyer = 0;
            for (int i = 0; i < n && i < MAXL; i++) anyer |= er[i];
            if (n < 5) begin
                stat = 2;
            end else if (n > MAXL) begin
                nb = MAXL - 4; user = 1; stat = 2;
            end else begin
                nb  = n - 4;
                fcs = {pay[nb+3], pay[nb+2], pay[nb+1], pay[nb]};
                bad = (crc32_of(nb) != fcs);
                stat = (anyer || n < MINL) ? 2 : (bad ? 1 : 0);
                user = (stat != 0);
            end
        end
        chk({tag, ".beats"}, q_data.size(), nb);
        mism = 0;
        for (int i = 0; i < nb && i < q_data.size(); i++) if (q_data[i] !== pay[i]) mism++;
        chk({tag, ".data_mism"}, mism, 0);
        nl = 0;
        foreach (q_last[i]) if (q_last[i]) nl++;
        chk({tag, ".tlast_cnt"}, nl, (nb > 0) ? 1 : 0);
        if (nb > 0 && q_data.size() == nb) begin
            chk({tag, ".tlast_pos"}, q_last[nb-1], 1);
            chk({tag, ".tuser"}, q_user[nb-1], user);
        end
        chk({tag, ".good"}, n_good, (stat == 0) ? 1 : 0);
        chk({tag, ".bad_fcs"}, n_fcs, (stat == 1) ? 1 : 0);
        chk({tag, ".error"}, n_err, (stat == 2) ? 1 : 0);
        chk({tag, ".lone_pulse"}, n_lone, (stat != 3 && nb == 0) ? 1 : 0);
    endtask

    task automatic run(input int npre, input logic [7:0] sfd, input int gap,
                       input int mode, input string tag);
        mon_clear();
        send(npre, sfd, gap);
        repeat (3) @(negedge clock);
        #1;
        compare(mode, tag);
    endtask

    task automatic outs_zero(input string tag);
        chk(tag, {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                  frame_good, frame_bad_fcs, frame_error}, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tab();
        #1;
        outs_zero("reset_outputs");
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        outs_zero("idle_outputs");

        build(60);                      run(7, 8'hD5, 3, 0, "good64");
        build(60); pay[10] ^= 8'h20;    run(7, 8'hD5, 3, 0, "bad_fcs");
        build(60); er[20] = 1'b1;       run(7, 8'hD5, 3, 0, "rx_er");
        pay.delete(); er.delete();
        for (int i = 0; i < 3; i++) begin pay.push_back(8'($urandom)); er.push_back(0); end
        run(7, 8'hD5, 3, 0, "runt3");
        build(36);                      run(7, 8'hD5, 3, 0, "runt40");

        pay.delete(); er.delete();
        for (int i = 0; i < 1600; i++) begin pay.push_back(8'($urandom)); er.push_back(0); end
        run(7, 8'hD5, 3, 0, "oversize");
        build(60);                      run(7, 8'hD5, 2, 0, "after_oversize");

        build(50);                      run(3, 8'h12, 3, 1, "preamble_err");
        build(46);                      run(0, 8'hD5, 1, 0, "sfd_only");

        en_div = 10;
        build(60);                      run(7, 8'hD5, 3, 0, "slow100M");
        chk("slow100M.consec_tvalid", n_consec, 0);
        en_div = 1;
        repeat (12) @(posedge clock);
        #1;

        // Reset in the middle of a frame's payload.
        build(60);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b1, pay[i], 1'b0);
        reset_n = 1'b0;
        #1;
        outs_zero("midframe_reset_outputs");
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        mon_clear();
        for (int i = 30; i < pay.size(); i++) drive(1'b1, pay[i], 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clock);
        #1;
        compare(2, "reset_rest");
        build(60);                      run(7, 8'hD5, 3, 0, "after_reset");

        // Randomized frames: length, corruption, rx_er, preamble, gap, enable rate.
        for (int f = 0; f < 12; f++) begin
            build($urandom_range(1, 120));
            if ($urandom_range(0, 3) == 0) pay[$urandom_range(0, pay.size() - 1)] ^= 8'h01;
            if ($urandom_range(0, 4) == 0) er[$urandom_range(0, pay.size() - 1)] = 1'b1;
            en_div = ($urandom_range(0, 2) == 0) ? 3 : 1;
            run($urandom_range(0, 7), 8'hD5, $urandom_range(1, 3), 0, $sformatf("rand%0d", f));
        end
        en_div = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gmii_rx_deframer.md
Name: gmii_rx_deframer

Overview:
- Receive-side GMII deframer for the SGMII Ethernet path. It is the receiving end of the GMII stream a 1G MAC transmitter produces.
- Consumes gmii_rxd/rx_dv/rx_er from the PCS/PMA, qualified by the SGMII clock enable.
- Strips preamble, SFD and FCS, checks CRC-32, length and rx_er.
- Emits frame bytes as an 8-bit AXI-Stream (no backpressure) into a downstream frame FIFO, plus per-frame status pulses.

Parameters:
MIN_FRAME_LENGTH, 64, minimum bytes after SFD including FCS; shorter frames are marked bad
MAX_FRAME_LENGTH, 1522, maximum bytes after SFD including FCS; longer frames are truncated and marked bad

Ports:
clock  input  1  125 MHz userclk2 domain; all logic on rising edge
reset_n  input  1  asynchronous assert, active-low reset
clk_enable  input  1  SGMII clock enable; GMII inputs sampled only when 1
gmii_rxd  input  8  receive data
gmii_rx_dv  input  1  receive data valid
gmii_rx_er  input  1  receive error
m_axis_tdata  output  8  frame byte
m_axis_tvalid  output  1  byte valid, exactly one clock per byte
m_axis_tlast  output  1  last payload byte of frame
m_axis_tuser  output  1  frame bad; meaningful with tlast only
frame_good  output  1  one-clock pulse: frame ended, no error
frame_bad_fcs  output  1  one-clock pulse: CRC residue mismatch
frame_error  output  1  one-clock pulse: rx_er, runt, oversize or preamble error

Behaviour:
- Reset (reset_n=0, async): state IDLE. All outputs 0, delay line empty, counters 0, CRC register 0xFFFFFFFF.
- Sampling rules:
  - GMII inputs are sampled only on clock edges where clk_enable=1. State and CRC update only on such edges.
  - All outputs are registered and return to 0 the next clock regardless of clk_enable, so no pulse exceeds one clock.
- State machine (transitions on enabled edges):
  - IDLE:
    - dv=1 & rxd=0x55 -> PREAMBLE.
    - dv=1 & rxd=0xD5 -> PAYLOAD.
    - dv=1 otherwise -> DROP, no output, no pulse.
  - PREAMBLE:
    - 0x55 stays.
    - 0xD5 -> PAYLOAD; CRC := 0xFFFFFFFF; count := 0; err := 0.
    - dv=0 -> IDLE.
    - Other byte -> DROP with frame_error pulse.
  - PAYLOAD, dv=1:
    - count++, CRC updated (reflected poly 0xEDB88320, LSB first), err |= rx_er.
    - Byte pushed into a 5-byte delay line. If the line already held 5 bytes, the oldest is emitted with tvalid=1, tlast=0.
  - PAYLOAD, dv=0 (end of frame):
    - If the line holds 5 bytes: emit oldest with tlast=1. The remaining 4 bytes are FCS and are discarded.
    - tuser=1 if err, or count<MIN_FRAME_LENGTH, or final CRC register != 0xDEBB20E3 (no final XOR).
    - Exactly one status pulse, in the same clock as tlast. Priority: frame_error (err or runt) > frame_bad_fcs > frame_good.
    - If fewer than 5 bytes are held: nothing emitted, frame_error pulses.
    - Then -> IDLE.
  - PAYLOAD, count would exceed MAX_FRAME_LENGTH:
    - Emit oldest held byte with tlast=1, tuser=1, frame_error pulse.
    - -> DROP.
  - DROP: wait for enabled edge with dv=0 -> IDLE.
- Latency: a byte appears on m_axis one clock after the enabled edge that samples the 5th byte following it (or the dv falling edge for the final byte).
- Never more than one tvalid per enabled edge. A frame's beats are always terminated by exactly one tlast.
- rx_er with dv=0 (carrier extension / false carrier) is ignored.
- A gap of one enabled cycle with dv=0 between frames is sufficient.
- Reset mid-frame: no tlast is emitted for the interrupted frame. After release, a frame in progress (dv=1 with non-preamble byte) goes to DROP.

Test Plan:
- Good 64-byte frame: 7x0x55, 0xD5, 60 data bytes, correct FCS, clk_enable=1 -> 60 tvalid beats matching data; tlast on beat 60, tuser=0; frame_good pulse same clock.
- Same frame with data byte 10 flipped -> 60 beats; tlast with tuser=1; frame_bad_fcs only.
- rx_er=1 on byte 20 of the good frame -> 60 beats; tuser=1; frame_error only.
- Runt: SFD + 3 bytes then dv=0 -> zero beats; one frame_error pulse. 40-byte frame with valid FCS -> 36 beats, tuser=1, frame_error.
- Oversize: 1600 bytes after SFD -> 1518 beats, last with tlast=1/tuser=1, frame_error. Following good frame is received normally.
- clk_enable high 1-in-10 (100 Mb/s) with the good 64-byte frame -> identical 60 beats, no consecutive tvalid, frame_good.
- reset_n pulsed low mid-payload -> outputs 0 immediately. The rest of that frame produces no beats or pulses, and the next good frame passes.
